// File: rtl/sc_ulpi_pkg.sv
// Shared types for the ULPI interface controller: arbiter state encoding
// and grant-vector bit positions.
package sc_ulpi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_REG = 2'd1,
        GNT_TXD = 2'd2,
        HOLDOFF = 2'd3
    } arb_state_t;

    localparam int GNT_REG_IDX = 0;
    localparam int GNT_TXD_IDX = 1;

endpackage

// File: rtl/sc_ulpi_uarb.sv
// Outbound PHY-bus arbiter between the register controller and the packet
// generator: one grant at a time, turnaround holdoff, starvation bound, ACK timeout.
module sc_ulpi_uarb
    import sc_ulpi_pkg::*;
#(
    parameter int HOLDOFF_CYC   = 2,
    parameter int TXD_BURST_MAX = 4,
    parameter int TIMEOUT_CYC   = 1024
) (
    input  logic       ULPICLK,
    input  logic       ULPIRSTB,
    input  logic       REG_REQ,
    output logic       REG_ACK,
    input  logic       TXD_REQ,
    output logic       TXD_ACK,
    output logic       UE_REG_REQ,
    input  logic       UE_REG_ACK,
    output logic       UE_TXD_REQ,
    input  logic       UE_TXD_ACK,
    input  logic       DIR,
    input  logic       CFG_REG_PRIO,
    output logic [1:0] ARB_GNT,
    output logic       ARB_BUSY,
    output logic       ARB_TIMEOUT,
    input  logic       ARB_TO_CLR
);

    localparam int HW = $clog2(HOLDOFF_CYC) + 1;
    localparam int BW = $clog2(TXD_BURST_MAX) + 1;
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYC > 0 ? HOLDOFF_CYC - 1 : 0);
    localparam logic [BW-1:0] BURST_MAX = BW'(TXD_BURST_MAX);
    // The flag is registered, so it is armed one count early to appear on the
    // cycle the counter reaches TIMEOUT_CYC-1; the counter then parks there.
    localparam logic [TW-1:0] TO_HIT    = TW'(TIMEOUT_CYC > 1 ? TIMEOUT_CYC - 2 : 0);
    localparam logic [TW-1:0] TO_SAT    = TW'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);

    arb_state_t    state_q, state_d;
    logic [HW-1:0] hold_cnt;
    logic [BW-1:0] burst_cnt;
    logic [TW-1:0] to_cnt;

    logic gnt_reg, gnt_txd, granted;
    logic reg_done, txd_done, done, abandon;
    logic pick_reg, to_set;

    assign gnt_reg  = (state_q == GNT_REG);
    assign gnt_txd  = (state_q == GNT_TXD);
    assign granted  = gnt_reg | gnt_txd;
    assign reg_done = gnt_reg & UE_REG_ACK;
    assign txd_done = gnt_txd & UE_TXD_ACK;
    assign done     = reg_done | txd_done;
    assign abandon  = (gnt_reg & ~REG_REQ) | (gnt_txd & ~TXD_REQ);
    assign pick_reg = REG_REQ & (~TXD_REQ | CFG_REG_PRIO | (burst_cnt >= BURST_MAX));
    assign to_set   = (TIMEOUT_CYC != 0) & granted & ~done & (to_cnt == TO_HIT);

    always_ff @(posedge ULPICLK or negedge ULPIRSTB) begin
        if (!ULPIRSTB) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!DIR && (REG_REQ || TXD_REQ))
                    state_d = pick_reg ? GNT_REG : GNT_TXD;
            end
            GNT_REG, GNT_TXD: begin
                if (done || abandon)
                    state_d = (HOLDOFF_CYC == 0) ? IDLE : HOLDOFF;
            end
            HOLDOFF: begin
                if (hold_cnt == HOLD_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ARB_GNT              = '0;
        ARB_GNT[GNT_REG_IDX] = gnt_reg;
        ARB_GNT[GNT_TXD_IDX] = gnt_txd;
        UE_REG_REQ           = gnt_reg & REG_REQ;
        UE_TXD_REQ           = gnt_txd & TXD_REQ;
        REG_ACK              = reg_done;
        TXD_ACK              = txd_done;
        ARB_BUSY             = (state_q != IDLE);
    end

    always_ff @(posedge ULPICLK or negedge ULPIRSTB) begin
        if (!ULPIRSTB) begin
            hold_cnt    <= '0;
            burst_cnt   <= '0;
            to_cnt      <= '0;
            ARB_TIMEOUT <= 1'b0;
        end else begin
            hold_cnt <= (state_q == HOLDOFF && hold_cnt != HOLD_LAST) ? hold_cnt + 1'b1 : '0;

            // Only packet completions that happen while a register access waits
            // count toward the starvation bound.
            if (state_q == IDLE && state_d == GNT_REG)
                burst_cnt <= '0;
            else if (txd_done)
                burst_cnt <= !REG_REQ ? '0 :
                             (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + 1'b1;

            if (!granted)
                to_cnt <= '0;
            else if (to_cnt != TO_SAT)
                to_cnt <= to_cnt + 1'b1;

            if (to_set)
                ARB_TIMEOUT <= 1'b1;
            else if (ARB_TO_CLR)
                ARB_TIMEOUT <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sc_ulpi_uarb.sv
// Directed bench for sc_ulpi_uarb: a transaction-level model checked every
// cycle, plus literal expectations taken from hand-worked timelines.
module tb_sc_ulpi_uarb;

    localparam int HOLD = 2;
    localparam int BMAX = 4;
    localparam int TO   = 16;

    logic       ULPICLK = 1'b0;
    logic       ULPIRSTB = 1'b0;
    logic       REG_REQ = 1'b0, TXD_REQ = 1'b0;
    logic       UE_REG_ACK = 1'b0, UE_TXD_ACK = 1'b0;
    logic       DIR = 1'b0, CFG_REG_PRIO = 1'b0, ARB_TO_CLR = 1'b0;
    logic       REG_ACK, TXD_ACK, UE_REG_REQ, UE_TXD_REQ;
    logic [1:0] ARB_GNT;
    logic       ARB_BUSY, ARB_TIMEOUT;

    int checks = 0;
    int failures = 0;
    logic cmp_en = 1'b0;

    sc_ulpi_uarb #(.HOLDOFF_CYC(HOLD), .TXD_BURST_MAX(BMAX), .TIMEOUT_CYC(TO)) dut (
        .ULPICLK(ULPICLK), .ULPIRSTB(ULPIRSTB),
        .REG_REQ(REG_REQ), .REG_ACK(REG_ACK),
        .TXD_REQ(TXD_REQ), .TXD_ACK(TXD_ACK),
        .UE_REG_REQ(UE_REG_REQ), .UE_REG_ACK(UE_REG_ACK),
        .UE_TXD_REQ(UE_TXD_REQ), .UE_TXD_ACK(UE_TXD_ACK),
        .DIR(DIR), .CFG_REG_PRIO(CFG_REG_PRIO),
        .ARB_GNT(ARB_GNT), .ARB_BUSY(ARB_BUSY),
        .ARB_TIMEOUT(ARB_TIMEOUT), .ARB_TO_CLR(ARB_TO_CLR)
    );

    always #5 ULPICLK = ~ULPICLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the bus (0 none, 1 reg, 2 txd), holdoff cycles left,
    // cycles already spent in the current grant, packet streak, timeout flag.
    int m_owner = 0, m_cool = 0, m_age = 0, m_streak = 0;
    int n_owner, n_cool, n_age, n_streak;
    logic m_flag = 1'b0, n_flag;

    always_comb begin
        logic ack, req, set;
        ack = 1'b0; req = 1'b0; set = 1'b0;
        n_owner = m_owner; n_cool = m_cool; n_age = m_age; n_streak = m_streak;
        if (m_owner != 0) begin
            ack = (m_owner == 1) ? UE_REG_ACK : UE_TXD_ACK;
            req = (m_owner == 1) ? REG_REQ : TXD_REQ;
            set = !ack && (m_age + 1 == TO - 1);
            if (m_owner == 2 && ack)
                n_streak = REG_REQ ? ((m_streak < BMAX) ? m_streak + 1 : BMAX) : 0;
            if (ack || !req) begin
                n_owner = 0;
                n_cool  = HOLD;
            end else begin
                n_age = m_age + 1;
            end
        end else if (m_cool > 0) begin
            n_cool = m_cool - 1;
        end else if (!DIR && (REG_REQ || TXD_REQ)) begin
            if (REG_REQ && (!TXD_REQ || CFG_REG_PRIO || m_streak >= BMAX)) begin
                n_owner  = 1;
                n_streak = 0;
            end else begin
                n_owner = 2;
            end
            n_age = 0;
        end
        n_flag = set ? 1'b1 : (ARB_TO_CLR ? 1'b0 : m_flag);
    end

    always @(posedge ULPICLK or negedge ULPIRSTB) begin
        if (!ULPIRSTB) begin
            m_owner <= 0; m_cool <= 0; m_age <= 0; m_streak <= 0; m_flag <= 1'b0;
        end else begin
            m_owner <= n_owner; m_cool <= n_cool; m_age <= n_age;
            m_streak <= n_streak; m_flag <= n_flag;
        end
    end

    always @(negedge ULPICLK) begin
        if (cmp_en) begin
            chk("cyc_gnt",     ARB_GNT, (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00);
            chk("cyc_ue_reg",  UE_REG_REQ, (m_owner == 1) && REG_REQ);
            chk("cyc_ue_txd",  UE_TXD_REQ, (m_owner == 2) && TXD_REQ);
            chk("cyc_reg_ack", REG_ACK, (m_owner == 1) && UE_REG_ACK);
            chk("cyc_txd_ack", TXD_ACK, (m_owner == 2) && UE_TXD_ACK);
            chk("cyc_busy",    ARB_BUSY, (m_owner != 0) || (m_cool > 0));
            chk("cyc_timeout", ARB_TIMEOUT, m_flag);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge ULPICLK);
        #1;
    endtask

    initial begin
        int txd_grants, w, bad;
        logic got_reg;

        #12;
        chk("rst_gnt", ARB_GNT, 0);
        chk("rst_busy", ARB_BUSY, 0);
        chk("rst_timeout", ARB_TIMEOUT, 0);
        chk("rst_ue_req", {UE_REG_REQ, UE_TXD_REQ}, 0);
        cmp_en = 1'b1;
        @(posedge ULPICLK); #1;
        ULPIRSTB = 1'b1;
        step(2);

        // Single register request, ACK at cycle 5, idle again at cycle 8.
        REG_REQ = 1; step(1);
        chk("t1_gnt_c1", ARB_GNT, 2'b01);
        chk("t1_uereq_c1", UE_REG_REQ, 1);
        step(4); UE_REG_ACK = 1; #1;
        chk("t1_ack_c5", REG_ACK, 1);
        step(1); UE_REG_ACK = 0; REG_REQ = 0;
        chk("t1_busy_c6", ARB_BUSY, 1);
        step(2);
        chk("t1_busy_c8", ARB_BUSY, 0);

        // Tie with packet priority, then with register priority.
        CFG_REG_PRIO = 0; REG_REQ = 1; TXD_REQ = 1; step(1);
        chk("t2_txd_first", ARB_GNT, 2'b10);
        step(9); UE_TXD_ACK = 1;
        step(1); UE_TXD_ACK = 0; TXD_REQ = 0;
        step(3);
        chk("t2_reg_c14", ARB_GNT, 2'b01);
        UE_REG_ACK = 1; step(1); UE_REG_ACK = 0; REG_REQ = 0; step(3);

        CFG_REG_PRIO = 1; REG_REQ = 1; TXD_REQ = 1; step(1);
        chk("t2_reg_first", ARB_GNT, 2'b01);
        UE_REG_ACK = 1; step(1); UE_REG_ACK = 0; REG_REQ = 0;
        step(3);
        chk("t2_txd_next", ARB_GNT, 2'b10);
        UE_TXD_ACK = 1; step(1); UE_TXD_ACK = 0; TXD_REQ = 0; step(3);
        CFG_REG_PRIO = 0;

        // Starvation bound: a continuous packet stream yields after BMAX grants.
        REG_REQ = 1; TXD_REQ = 1;
        txd_grants = 0; got_reg = 0;
        for (int k = 0; k < 6 && !got_reg; k++) begin
            w = 0;
            while (ARB_GNT == 2'b00 && w < 20) begin step(1); w++; end
            chk("t3_gnt_seen", ARB_GNT != 2'b00, 1);
            if (ARB_GNT == 2'b10) begin
                txd_grants++;
                UE_TXD_ACK = 1; step(1); UE_TXD_ACK = 0;
            end else if (ARB_GNT == 2'b01) begin
                got_reg = 1;
            end else begin
                break;
            end
        end
        chk("t3_txd_grants", txd_grants, BMAX);
        chk("t3_reg_after", ARB_GNT, 2'b01);
        UE_REG_ACK = 1; step(1); UE_REG_ACK = 0; REG_REQ = 0; TXD_REQ = 0; step(3);

        // DIR=1 blocks grants; DIR rising mid-grant does not revoke it.
        DIR = 1; REG_REQ = 1; bad = 0;
        for (int i = 0; i < 21; i++) begin
            bad += (ARB_GNT != 2'b00) ? 1 : 0;
            step(1);
        end
        chk("t4_no_gnt_dir", bad, 0);
        DIR = 0; step(1);
        chk("t4_gnt_c22", ARB_GNT, 2'b01);
        DIR = 1; step(1);
        chk("t4_gnt_kept", ARB_GNT, 2'b01);
        chk("t4_uereq_kept", UE_REG_REQ, 1);
        UE_REG_ACK = 1; step(1); UE_REG_ACK = 0; REG_REQ = 0; DIR = 0; step(3);

        // Timeout at grant cycle 16, clear, then clear coincident with set.
        REG_REQ = 1; step(1);
        step(14);
        chk("t5_flag_g15", ARB_TIMEOUT, 0);
        step(1);
        chk("t5_flag_g16", ARB_TIMEOUT, 1);
        chk("t5_gnt_g16", ARB_GNT, 2'b01);
        step(1); ARB_TO_CLR = 1;
        step(1); ARB_TO_CLR = 0;
        chk("t5_cleared", ARB_TIMEOUT, 0);
        chk("t5_gnt_still", ARB_GNT, 2'b01);
        UE_REG_ACK = 1; step(1); UE_REG_ACK = 0; REG_REQ = 0; step(3);

        REG_REQ = 1; step(1);
        step(14);
        chk("t5b_flag_g15", ARB_TIMEOUT, 0);
        ARB_TO_CLR = 1;
        step(1); ARB_TO_CLR = 0;
        chk("t5b_set_wins", ARB_TIMEOUT, 1);
        UE_REG_ACK = 1; step(1); UE_REG_ACK = 0; REG_REQ = 0;
        ARB_TO_CLR = 1; step(1); ARB_TO_CLR = 0; step(2);

        // Abandon: no ACK forwarded, late engine ACK dropped.
        REG_REQ = 1; step(1);
        step(2); REG_REQ = 0; #1;
        chk("t6_uereq_drop", UE_REG_REQ, 0);
        step(1); UE_REG_ACK = 1; #1;
        chk("t6_late_ack", REG_ACK, 0);
        chk("t6_holdoff_busy", ARB_BUSY, 1);
        chk("t6_holdoff_gnt", ARB_GNT, 2'b00);
        step(1); UE_REG_ACK = 0; step(3);

        // Asynchronous reset in the middle of a packet grant.
        TXD_REQ = 1; step(2);
        chk("t7_gnt_pre", ARB_GNT, 2'b10);
        #2 ULPIRSTB = 0;
        #1;
        chk("t7_rst_gnt", ARB_GNT, 2'b00);
        chk("t7_rst_uereq", UE_TXD_REQ, 0);
        chk("t7_rst_busy", ARB_BUSY, 0);
        step(1); ULPIRSTB = 1;
        chk("t7_idle_after", ARB_BUSY, 0);
        step(1);
        chk("t7_regrant", ARB_GNT, 2'b10);
        UE_TXD_ACK = 1; step(1); UE_TXD_ACK = 0; TXD_REQ = 0; step(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sc_ulpi_uarb.md
Name: sc_ulpi_uarb

Overview:
- Arbitrates the ULPI Protocol Engine's outbound PHY bus between two requesters: the register requester (register controller) and the packet requester (packet generator).
- Sits inside the ULPI interface controller, between those requesters and the engine, and grants exactly one transaction at a time.
- Enforces a bus-turnaround holdoff and a starvation bound on register accesses, and flags engine non-response.
- Payload buses (REG_CCD/CPD/EXT_ADDR/TX_DATA, TXD_CPD/VALID/READY/LAST/DATA) bypass this block; only REQ/ACK are gated here.

Parameters:
HOLDOFF_CYC, 2, idle cycles inserted after each completed or abandoned grant (0 = none)
TXD_BURST_MAX, 4, max consecutive packet grants while a register request waits (>=1)
TIMEOUT_CYC, 1024, grant cycles without engine ACK before ARB_TIMEOUT sets (0 = disabled)

Ports:
ULPICLK  in  1  ULPI clock, 60 MHz
ULPIRSTB  in  1  reset, asynchronous, active-low
REG_REQ  in  1  register requester request; held until REG_ACK
REG_ACK  out  1  register transaction complete, 1-cycle pulse
TXD_REQ  in  1  packet requester request; held until TXD_ACK
TXD_ACK  out  1  packet transaction complete, 1-cycle pulse
UE_REG_REQ  out  1  register request forwarded to engine
UE_REG_ACK  in  1  engine register completion pulse
UE_TXD_REQ  out  1  packet request forwarded to engine
UE_TXD_ACK  in  1  engine packet completion pulse
DIR  in  1  PHY bus direction; 1 = PHY owns bus
CFG_REG_PRIO  in  1  1 = register wins ties; 0 = packet wins ties
ARB_GNT  out  2  one-hot grant, [0] = REG, [1] = TXD
ARB_BUSY  out  1  state != IDLE
ARB_TIMEOUT  out  1  sticky: engine ACK timeout occurred
ARB_TO_CLR  in  1  clears ARB_TIMEOUT

Behaviour:
- Reset: state IDLE; ARB_GNT, ARB_BUSY, ARB_TIMEOUT, all REQ/ACK outputs 0; all counters 0. Applies asynchronously, including mid-grant.
- States: IDLE, GNT_REG, GNT_TXD, HOLDOFF.
- IDLE, DIR=0: evaluate REG_REQ and TXD_REQ.
  - Only one request: grant it.
  - Both requests: REG if burst_cnt >= TXD_BURST_MAX; else REG if CFG_REG_PRIO = 1; else TXD.
  - The grant state is registered and entered on the next cycle.
- IDLE, DIR=1: no grant. Requests wait.
- DIR changing while in a GNT state has no effect on the grant.
- GNT_x, forwarding (combinational):
  - UE_x_REQ = x_REQ while granted.
  - x_ACK = UE_x_ACK while granted.
  - ARB_GNT reflects the state.
- Ungranted side: engine ACKs are dropped, never forwarded.
- GNT_x exit: UE_x_ACK=1 goes to HOLDOFF. x_REQ=0 before an ACK is an abandon; it also goes to HOLDOFF, with no ACK forwarded.
- Minimum latency: REQ at cycle N gives UE_REQ at N+1.
- burst_cnt (saturating):
  - Increments on each TXD completion where REG_REQ = 1.
  - Clears on REG grant.
  - Clears on any TXD completion where REG_REQ = 0.
- HOLDOFF: counts HOLDOFF_CYC cycles, then IDLE. With HOLDOFF_CYC = 0, GNT goes directly to IDLE.
- Back-to-back grant cadence: ACK cycle, then HOLDOFF_CYC cycles, then 1 IDLE cycle, then next GNT.
- Timeout counter:
  - Clears on GNT entry and increments each GNT cycle.
  - Reaching TIMEOUT_CYC-1 with no ACK sets ARB_TIMEOUT. The grant is not revoked.
  - ARB_TO_CLR clears the flag. Set wins over a simultaneous clear.
- Counter widths: $clog2 of the respective parameter + 1.

Decomposition:
- Shared package sc_ulpi_pkg:
  - arb_state_t enum: IDLE, GNT_REG, GNT_TXD, HOLDOFF.
  - Grant index constants: GNT_REG_IDX = 0, GNT_TXD_IDX = 1.
- No sub-module: a single FSM plus three counters.
- Instantiated in the ULPI interface controller between the requesters and the engine REQ/ACK pins.

Test Plan:
- Single register request: REG_REQ=1 at cycle 0, DIR=0 -> ARB_GNT=01 and UE_REG_REQ=1 at cycle 1. UE_REG_ACK at cycle 5 -> REG_ACK at cycle 5. ARB_BUSY=0 at cycle 8 (HOLDOFF_CYC=2).
- Tie, CFG_REG_PRIO=0: both requests at cycle 0 -> TXD granted at cycle 1. TXD ack at cycle 10 -> REG granted at cycle 14. Repeat with CFG_REG_PRIO=1 -> REG granted first.
- Starvation: TXD_REQ re-asserted continuously, REG_REQ held, TXD_BURST_MAX=4 -> exactly 4 TXD grants, then ARB_GNT=01.
- DIR hold-off: requests during DIR=1 (cycles 0-20) -> no grant. DIR falls at cycle 21 -> grant at cycle 22. DIR rising mid-grant leaves the grant intact.
- Timeout: TIMEOUT_CYC=16, no engine ACK -> ARB_TIMEOUT=1 at grant cycle 16 with ARB_GNT unchanged. ARB_TO_CLR clears it. Clear coincident with set leaves the flag at 1.
- Abandon and reset: REG_REQ dropped mid-grant -> no REG_ACK, HOLDOFF entered, a late UE_REG_ACK is ignored. ULPIRSTB low mid-GNT_TXD -> all outputs 0 immediately (asynchronous), IDLE after release.
